// File: rtl/score_display.sv
// Decimal score overlay: double-dabble BCD converter with frame-synchronous commit,
// followed by a 2-cycle glyph renderer producing registered RGB and an opacity flag.
module score_display #(
   parameter int         NUM_DIGITS = 4,
   parameter int         SCORE_W    = 14,
   parameter int         GLYPH_W    = 8,
   parameter int         GLYPH_H    = 16,
   parameter int         SCALE_LOG2 = 1,
   parameter int         X0         = 16,
   parameter int         Y0         = 16,
   parameter int         LZ_BLANK   = 1,
   parameter logic [3:0] FG_R       = 4'hF,
   parameter logic [3:0] FG_G       = 4'hF,
   parameter logic [3:0] FG_B       = 4'hF
) (
   input  logic               vga_clk,
   input  logic               reset,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic               blank,
   input  logic [SCORE_W-1:0] score_value,
   input  logic               score_load,
   output logic               busy,
   output logic               pixel_on,
   output logic [3:0]         red,
   output logic [3:0]         green,
   output logic [3:0]         blue
);

   localparam int BCD_W  = 4 * NUM_DIGITS;
   localparam int SH_W   = BCD_W + SCORE_W;
   localparam int GW_L   = $clog2(GLYPH_W);
   localparam int GH_L   = $clog2(GLYPH_H);
   localparam int ADDR_W = 4 + GH_L + GW_L;
   localparam int CNT_W  = $clog2(SCORE_W + 1);
   localparam logic [10:0] X_BEG   = 11'(X0);
   localparam logic [10:0] X_END   = 11'(X0 + NUM_DIGITS * GLYPH_W * (2 ** SCALE_LOG2));
   localparam logic [10:0] Y_BEG   = 11'(Y0);
   localparam logic [10:0] Y_END   = 11'(Y0 + GLYPH_H * (2 ** SCALE_LOG2));
   localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] sh);
      logic [SH_W-1:0] t;
      t = sh;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (t[SCORE_W + 4*i +: 4] >= 4'd5)
            t[SCORE_W + 4*i +: 4] = t[SCORE_W + 4*i +: 4] + 4'd3;
      end
      return t << 1;
   endfunction

   function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] bcd, input logic sat);
      return sat ? {NUM_DIGITS{4'h9}} : bcd;
   endfunction

   // Seven-segment style glyphs: bars on rows 1, H/2, H-2 and columns 1, W-2.
   function automatic logic glyph_bit(input logic [ADDR_W-1:0] a);
      logic [3:0] dig;
      logic [6:0] seg;
      int         r, c;
      logic       hz, vt, vb;
      dig = a[ADDR_W-1 -: 4];
      r   = int'(a[GW_L +: GH_L]);
      c   = int'(a[GW_L-1:0]);
      case (dig)
         4'd0: seg = 7'h7E;
         4'd1: seg = 7'h30;
         4'd2: seg = 7'h6D;
         4'd3: seg = 7'h79;
         4'd4: seg = 7'h33;
         4'd5: seg = 7'h5B;
         4'd6: seg = 7'h5F;
         4'd7: seg = 7'h70;
         4'd8: seg = 7'h7F;
         4'd9: seg = 7'h7B;
         default: seg = 7'h00;
      endcase
      hz = (c >= 1) && (c <= GLYPH_W - 2);
      vt = (r >= 1) && (r <= GLYPH_H / 2);
      vb = (r >= GLYPH_H / 2) && (r <= GLYPH_H - 2);
      return (seg[6] && r == 1 && hz) || (seg[5] && c == GLYPH_W - 2 && vt) ||
             (seg[4] && c == GLYPH_W - 2 && vb) || (seg[3] && r == GLYPH_H - 2 && hz) ||
             (seg[2] && c == 1 && vb) || (seg[1] && c == 1 && vt) ||
             (seg[0] && r == GLYPH_H / 2 && hz);
   endfunction

   state_t             state_q;
   logic [SH_W-1:0]    sh_q;
   logic               sat_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic [BCD_W-1:0]   pend_q;
   logic               pend_vld_q;
   logic               req_vld_q;
   logic [SCORE_W-1:0] req_val_q;
   logic [SCORE_W-1:0] start_val;
   logic               commit;

   assign start_val = score_load ? score_value : req_val_q;
   assign commit    = (DrawX == 10'd0) && (DrawY == 10'd0) && pend_vld_q;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         req_vld_q  <= 1'b0;
         req_val_q  <= '0;
      end else begin
         if (commit) pend_vld_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (score_load || req_vld_q) begin
                  sh_q      <= {{BCD_W{1'b0}}, start_val};
                  sat_q     <= 64'(start_val) > MAX_VAL;
                  cnt_q     <= CNT_W'(SCORE_W);
                  busy_q    <= 1'b1;
                  req_vld_q <= 1'b0;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               sh_q  <= dd_step(sh_q);
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_q <= DONE;
            end
            DONE: begin
               pend_q     <= sat_bcd(sh_q[SH_W-1 -: BCD_W], sat_q);
               pend_vld_q <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         // Loads arriving mid-conversion park here; the newest one overwrites.
         if (busy_q && score_load) begin
            req_vld_q <= 1'b1;
            req_val_q <= score_value;
         end
      end
   end

   logic [BCD_W-1:0] disp_d, disp_q;

   always_comb disp_d = commit ? pend_q : disp_q;

   always_ff @(posedge vga_clk) begin
      if (reset) disp_q <= '0;
      else       disp_q <= disp_d;
   end

   // S0: hit test, digit select, leading-zero blanking, ROM address
   logic [10:0]       dx, dy, lx, dig_idx;
   logic [GH_L-1:0]   row;
   logic              in_box, lead, blk, sel_blk;
   logic [3:0]        sel_dig;
   logic [ADDR_W-1:0] addr_d;

   always_comb begin
      dx      = {1'b0, DrawX} - X_BEG;
      dy      = {1'b0, DrawY} - Y_BEG;
      lx      = dx >> SCALE_LOG2;
      row     = GH_L'(dy >> SCALE_LOG2);
      in_box  = ({1'b0, DrawX} >= X_BEG) && ({1'b0, DrawX} < X_END) &&
                ({1'b0, DrawY} >= Y_BEG) && ({1'b0, DrawY} < Y_END);
      dig_idx = lx >> GW_L;
      lead    = 1'b1;
      blk     = 1'b0;
      sel_dig = 4'd0;
      sel_blk = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         lead = lead && (disp_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
         blk  = (LZ_BLANK != 0) && lead && (i != NUM_DIGITS - 1);
         if (dig_idx == 11'(i)) begin
            sel_dig = disp_q[4*(NUM_DIGITS-1-i) +: 4];
            sel_blk = blk;
         end
      end
      addr_d = {sel_dig, row, GW_L'(lx)};
   end

   logic [ADDR_W-1:0] addr_p0_q;
   logic              hit_p0_q, vld_p0_q, lzb_p0_q;

   always_ff @(posedge vga_clk) begin
      addr_p0_q <= addr_d;
      if (reset) begin
         hit_p0_q <= 1'b0;
         vld_p0_q <= 1'b0;
         lzb_p0_q <= 1'b0;
      end else begin
         hit_p0_q <= in_box;
         vld_p0_q <= blank;
         lzb_p0_q <= sel_blk;
      end
   end

   // S1: ROM output, one cycle after the address was presented
   logic rom_bit;
   assign rom_bit = glyph_bit(addr_p0_q);

   // S2: output registers
   logic       opaque_d, pixel_on_q;
   logic [3:0] red_d, green_d, blue_d, red_q, green_q, blue_q;

   always_comb begin
      opaque_d = hit_p0_q && vld_p0_q && !lzb_p0_q && rom_bit;
      red_d    = opaque_d ? FG_R : 4'h0;
      green_d  = opaque_d ? FG_G : 4'h0;
      blue_d   = opaque_d ? FG_B : 4'h0;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         pixel_on_q <= 1'b0;
         red_q      <= 4'h0;
         green_q    <= 4'h0;
         blue_q     <= 4'h0;
      end else begin
         pixel_on_q <= opaque_d;
         red_q      <= red_d;
         green_q    <= green_d;
         blue_q     <= blue_d;
      end
   end

   assign busy     = busy_q;
   assign pixel_on = pixel_on_q;
   assign red      = red_q;
   assign green    = green_q;
   assign blue     = blue_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: a cycle model of the converter and frame commit predicts
// each rendered pixel, queued at drive time and compared two cycles later.
module tb_score_display;

   localparam int ND = 4;
   localparam int SW = 14;
   localparam int X0 = 16;
   localparam int Y0 = 16;
   localparam int BW = 64;
   localparam int BH = 32;

   logic          vga_clk = 1'b0;
   logic          reset = 1'b1;
   logic [9:0]    DrawX = 10'd600;
   logic [9:0]    DrawY = 10'd400;
   logic          blank = 1'b0;
   logic [SW-1:0] score_value = '0;
   logic          score_load = 1'b0;
   logic          busy, pixel_on;
   logic [3:0]    red, green, blue;

   score_display dut (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .score_value(score_value), .score_load(score_load), .busy(busy),
      .pixel_on(pixel_on), .red(red), .green(green), .blue(blue)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      logic [12:0] exp;
      int          x;
      int          y;
   } ent_t;

   ent_t  sb[$];
   bit    glyph[10][16][8];
   int    n_tests = 0;
   int    n_fail = 0;
   int    busy_hi = 0;
   int    on_d01 = 0;
   int    on_d23 = 0;
   bit    started = 0;

   int    m_disp[ND];
   int    m_pend[ND];
   bit    m_pv = 0;
   int    m_cnt = 0;
   int    m_val = 0;
   bit    m_req_v = 0;
   int    m_req_val = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] exp_pix(input int x, input int y, input bit b);
      int lx, ly, d;
      bit blk;
      if (!b || x < X0 || x >= X0 + BW || y < Y0 || y >= Y0 + BH) return 13'h0;
      lx  = (x - X0) / 2;
      ly  = (y - Y0) / 2;
      d   = lx / 8;
      blk = (d != ND - 1);
      for (int i = 0; i <= d; i++) if (m_disp[i] != 0) blk = 0;
      if (blk || !glyph[m_disp[d]][ly][lx % 8]) return 13'h0;
      return 13'h1FFF;
   endfunction

   task automatic model_step(input int x, input int y, input bit ld, input int val);
      bit cm, dn;
      cm = (x == 0 && y == 0 && m_pv);
      dn = (m_cnt == 1);
      if (cm) begin
         m_disp = m_pend;
         m_pv   = 0;
      end
      if (dn) begin
         for (int i = 0; i < ND; i++)
            m_pend[i] = (m_val > 9999) ? 9 : (m_val / (10 ** (ND - 1 - i))) % 10;
         m_pv = 1;
      end
      if (m_cnt != 0) begin
         if (ld) begin
            m_req_v   = 1;
            m_req_val = val;
         end
         m_cnt--;
      end else if (ld) begin
         m_val   = val;
         m_cnt   = SW + 1;
         m_req_v = 0;
      end else if (m_req_v) begin
         m_val   = m_req_val;
         m_cnt   = SW + 1;
         m_req_v = 0;
      end
   endtask

   task automatic tick(input int x, input int y, input bit b, input bit ld, input int val,
                       input bit rst);
      ent_t e;
      @(negedge vga_clk);
      if (sb.size() >= 2) begin
         e = sb.pop_front();
         chk($sformatf("pix(%0d,%0d)", e.x, e.y), 32'({pixel_on, red, green, blue}),
             32'(e.exp));
         if (pixel_on === 1'b1) begin
            if (e.x < X0 + 32) on_d01++;
            else               on_d23++;
         end
      end
      if (started) begin
         chk("busy", 32'(busy), 32'(m_cnt != 0));
         if (busy === 1'b1) busy_hi++;
      end
      DrawX       = 10'(x);
      DrawY       = 10'(y);
      blank       = b;
      score_load  = ld;
      score_value = SW'(val);
      reset       = rst;
      e.x = x;
      e.y = y;
      if (rst) begin
         for (int i = 0; i < sb.size(); i++) sb[i].exp = 13'h0;
         e.exp = 13'h0;
         sb.push_back(e);
         for (int i = 0; i < ND; i++) begin
            m_disp[i] = 0;
            m_pend[i] = 0;
         end
         m_pv      = 0;
         m_cnt     = 0;
         m_req_v   = 0;
         m_req_val = 0;
         started   = 1;
      end else begin
         e.exp = exp_pix(x, y, b);
         sb.push_back(e);
         model_step(x, y, ld, val);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick(600, 400, 0, 0, 0, 0);
   endtask

   task automatic load(input int v);
      tick(600, 400, 0, 1, v, 0);
   endtask

   task automatic frame();
      tick(0, 0, 1, 0, 0, 0);
      for (int y = Y0 - 2; y < Y0 + BH + 2; y++)
         for (int x = X0 - 2; x < X0 + BW + 2; x++)
            tick(x, y, ((x + y) % 7) != 0, 0, 0, 0);
   endtask

   string segs[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

   initial begin
      for (int d = 0; d < 10; d++) begin
         for (int k = 0; k < segs[d].len(); k++) begin
            case (segs[d][k])
               "a": for (int c = 1; c <= 6; c++) glyph[d][1][c] = 1;
               "b": for (int r = 1; r <= 8; r++) glyph[d][r][6] = 1;
               "c": for (int r = 8; r <= 14; r++) glyph[d][r][6] = 1;
               "d": for (int c = 1; c <= 6; c++) glyph[d][14][c] = 1;
               "e": for (int r = 8; r <= 14; r++) glyph[d][r][1] = 1;
               "f": for (int r = 1; r <= 8; r++) glyph[d][r][1] = 1;
               "g": for (int c = 1; c <= 6; c++) glyph[d][8][c] = 1;
               default: ;
            endcase
         end
      end
      for (int i = 0; i < ND; i++) begin
         m_disp[i] = 0;
         m_pend[i] = 0;
      end

      repeat (3) tick(600, 400, 0, 0, 0, 1);
      idle(4);
      frame();

      busy_hi = 0;
      load(1234);
      frame();
      chk("busy_len", 32'(busy_hi), 32'd15);
      frame();

      load(42);
      idle(20);
      on_d01 = 0;
      on_d23 = 0;
      frame();
      chk("lz42_d01", 32'(on_d01), 32'd0);
      chk("lz42_d23", 32'(on_d23 > 0), 32'd1);

      load(0);
      idle(20);
      frame();

      load(12000);
      idle(20);
      frame();

      load(100);
      idle(1);
      load(200);
      idle(5);
      load(300);
      idle(40);
      frame();

      tick(X0 - 1, Y0, 1, 0, 0, 0);
      tick(X0, Y0, 1, 0, 0, 0);
      tick(X0 + 63, Y0 + 31, 1, 0, 0, 0);
      tick(X0 + 64, Y0, 1, 0, 0, 0);
      tick(66, 18, 1, 0, 0, 0);
      tick(66, 18, 0, 0, 0, 0);
      tick(36, 18, 1, 0, 0, 0);
      tick(36, 18, 0, 0, 0, 0);
      idle(3);

      load(5555);
      idle(5);
      tick(66, 18, 1, 0, 0, 0);
      tick(36, 18, 1, 0, 0, 0);
      tick(36, 18, 1, 0, 0, 1);
      idle(3);
      frame();
      frame();
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/score_display.md
# score_display

Parametrised N-digit decimal score renderer for the VGA pixel pipeline. It takes a binary score, converts it sequentially to BCD, and commits the new digits only at frame start so the display never tears. It then draws the digits as scaled 1-bit glyphs at a fixed screen position. It sits beside the other sprite renderers and feeds the frame compositor through a registered RGB output plus an opacity flag.

## Interface
Parameters:
- NUM_DIGITS, 4: number of displayed decimal digits (1–6).
- SCORE_W, 14: width of the binary score input.
- GLYPH_W, 8: glyph width in ROM pixels; must be a power of 2.
- GLYPH_H, 16: glyph height in ROM pixels; must be a power of 2.
- SCALE_LOG2, 1: screen magnification is 2^SCALE_LOG2 in both axes.
- X0, 16: left edge of the score box, in screen pixels.
- Y0, 16: top edge of the score box, in screen pixels.
- LZ_BLANK, 1: when 1, leading zeros are blanked; the units digit is always drawn.
- FG_R, FG_G, FG_B, 4'hF: 4-bit glyph foreground colour channels.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video region.
- score_value  in  SCORE_W  binary score.
- score_load  in  1  one-cycle pulse that samples score_value.
- busy  out  1  BCD conversion in progress.
- pixel_on  out  1  registered; the current output pixel is an opaque glyph pixel.
- red, green, blue  out  4 each  registered colour.

## Operation
- Converter FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: on score_load, latch score_value, clear the BCD shift register, load the shift counter with SCORE_W, and go to SHIFT.
  - SHIFT: one double-dabble iteration per cycle. Every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left by 1. After SCORE_W iterations, go to DONE.
  - DONE: write the result to the pending register, set pending_valid, and go to IDLE.
- busy is high in SHIFT and DONE.
- Saturation: if the latched value > 10^NUM_DIGITS − 1, the pending digits are all 9.
- score_load while busy: score_value goes into a one-deep request register; the latest request wins. It starts on the cycle after DONE.
- Frame commit: on the cycle with DrawX==0 and DrawY==0, if pending_valid, copy pending to the displayed digits and clear pending_valid. If DONE occurs in that same cycle, the new result waits for the next frame.
- Hit test: the box spans X0 ≤ DrawX < X0 + NUM_DIGITS·GLYPH_W·2^S and Y0 ≤ DrawY < Y0 + GLYPH_H·2^S, where S = SCALE_LOG2. All comparisons are unsigned.
- Coordinates inside the box:
  - lx = (DrawX − X0) >> S; ly = (DrawY − Y0) >> S.
  - Digit index = lx / GLYPH_W, where index 0 is the most significant digit.
  - col = lx mod GLYPH_W; row = ly.
- Glyph ROM: 1 bit wide, 10·GLYPH_W·GLYPH_H deep, read latency 1. Address = digit·GLYPH_W·GLYPH_H + row·GLYPH_W + col.
- Leading-zero blanking (LZ_BLANK=1): a digit is blanked if it and every more significant digit are 0, and it is not the units digit. A blanked digit is never opaque.
- Output per pixel:
  - Opaque when in the box, not blanked, ROM bit = 1, and blank = 1. Then RGB = FG and pixel_on = 1.
  - Otherwise RGB = 0 and pixel_on = 0.

## Timing
- Reset values:
  - red, green, blue, pixel_on, busy: 0.
  - FSM state: IDLE.
  - Displayed digits, pending register, pending_valid, request register: all 0.
- Reset mid-conversion aborts the conversion and discards any pending result.
- Render pipeline, 2-cycle latency from DrawX/DrawY/blank to red/green/blue/pixel_on:
  - S0: hit test, registered ROM address, and registered hit/blank/blanked flags.
  - S1: ROM q is valid.
  - S2: output registers.
- blank and the hit flags are delayed alongside the address so all of them align with q.
- Conversion latency: busy rises the cycle after score_load and stays high for SCORE_W+1 cycles. Then pending_valid = 1.
- Display update: the first frame whose (0,0) pixel arrives after pending_valid is set.
- One pixel per cycle with no stalls; the renderer never back-pressures the input.

## Test plan
- Reset, then load 1234 and drive a full frame. busy is high for 15 cycles. The digits are unchanged until the next (0,0) pixel, and digits "1234" are drawn from the frame after that. Output pixels are checked against a golden model, 2 cycles delayed.
- Load 42 with LZ_BLANK=1. Only digits 2 and 3 produce pixel_on; digits 0 and 1 never do. Load 0: only the units digit is drawn.
- Load 12000 with SCORE_W=14. The displayed value is 9999.
- Load 100, then load 200 two cycles later, then load 300 while still busy. The final displayed value is 300 and the 200 result is never committed.
- Drive pixels on the box edges: (X0−1,Y0), (X0,Y0), (X0+63,Y0+31), (X0+64,Y0), and also with blank=0 inside the box. Only the in-box pixels with blank=1 can be opaque, and pixel_on/RGB are 0 for the rest.
- Assert reset during SHIFT of a load of 5555. All outputs are 0 on the next cycle, the displayed digits are 0, and there is no commit at the next frame start.
